result_tx_serializer: RTL

Drains one finished result from the processing core into the byte-wide UART transmit path. On `start` it takes the scalar result or the vector result, selected by `out_mode`, and emits it as a stream of bytes, least-significant byte first, over a valid/ready handshake. It pulses `done` after the last byte has been accepted. It sits between the processing core outputs and the UART transmitter, and is the return half of the command/receive path.

---
 rtl/result_tx_pkg.sv | 22 ++
 rtl/result_byte_sel.sv | 34 +++
 rtl/result_tx_serializer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/result_tx_pkg.sv
// Shared types and sizing helpers for the result transmit serializer.
package result_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    function automatic int calc_scalar_w(input int depth, input int width);
        return $clog2(depth) + 10 + width;
    endfunction

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/result_byte_sel.sv
// Combinational byte picker: selects the current outgoing byte from the captured scalar or the live vector.
module result_byte_sel
    import result_tx_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 1024,
    parameter int SCALAR_W = calc_scalar_w(DEPTH, WIDTH),
    parameter int IDX_W    = max2(1, $clog2(DEPTH)),
    parameter int BYTE_W   = max2(1, $clog2(max2(bytes_for(SCALAR_W), bytes_for(WIDTH))))
) (
    input  logic                         mode_i,
    input  logic [SCALAR_W-1:0]          scalar_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]  vec_i,
    input  logic [IDX_W-1:0]             elem_idx_i,
    input  logic [BYTE_W-1:0]            byte_idx_i,
    output logic [7:0]                   byte_o
);

    localparam int SB = bytes_for(SCALAR_W);
    localparam int EB = bytes_for(WIDTH);

    logic [SB*8-1:0] w_sc_ext;
    logic [EB*8-1:0] w_el_ext;
    logic [SB*8-1:0] w_sc_sh;
    logic [EB*8-1:0] w_el_sh;

    // Zero-extend to whole bytes, then shift the wanted byte down to the LSB.
    assign w_sc_ext = (SB*8)'(scalar_i);
    assign w_el_ext = (EB*8)'(vec_i[elem_idx_i]);
    assign w_sc_sh  = w_sc_ext >> {byte_idx_i, 3'b000};
    assign w_el_sh  = w_el_ext >> {byte_idx_i, 3'b000};
    assign byte_o   = mode_i ? w_el_sh[7:0] : w_sc_sh[7:0];

endmodule

// File: rtl/result_tx_serializer.sv
// Streams one scalar or vector result LSB-first as bytes over a valid/ready handshake, then pulses done.
module result_tx_serializer
    import result_tx_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 1024,
    parameter int SCALAR_W = calc_scalar_w(DEPTH, WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         out_mode,
    input  logic [SCALAR_W-1:0]          result_scalar,
    input  logic [DEPTH-1:0][WIDTH-1:0]  result_vec,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int SB     = bytes_for(SCALAR_W);
    localparam int EB     = bytes_for(WIDTH);
    localparam int VEC_N  = DEPTH * EB;
    localparam int MAX_N  = max2(SB, VEC_N);
    localparam int CNT_W  = max2(1, $clog2(MAX_N + 1));
    localparam int IDX_W  = max2(1, $clog2(DEPTH));
    localparam int BYTE_W = max2(1, $clog2(max2(SB, EB)));

    tx_state_t           state_q, state_d;
    logic                mode_q, mode_d;
    logic [SCALAR_W-1:0] scalar_q, scalar_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;

    logic [7:0]          sel_byte;
    logic                last_total;
    logic                last_in_unit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            scalar_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            byte_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            scalar_q <= scalar_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
        end
    end

    // A scalar is a single "element" of SB bytes, so only the vector path ever bumps idx.
    assign last_total   = mode_q ? (cnt_q == CNT_W'(VEC_N - 1)) : (cnt_q == CNT_W'(SB - 1));
    assign last_in_unit = mode_q ? (byte_q == BYTE_W'(EB - 1))  : (byte_q == BYTE_W'(SB - 1));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        scalar_d = scalar_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEND;
                    mode_d   = out_mode;
                    scalar_d = result_scalar;
                    cnt_d    = '0;
                    idx_d    = '0;
                    byte_d   = '0;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (last_total) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (last_in_unit) begin
                            byte_d = '0;
                            idx_d  = idx_q + 1'b1;
                        end else begin
                            byte_d = byte_q + 1'b1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    result_byte_sel #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .SCALAR_W (SCALAR_W),
        .IDX_W    (IDX_W),
        .BYTE_W   (BYTE_W)
    ) u_byte_sel (
        .mode_i     (mode_q),
        .scalar_i   (scalar_q),
        .vec_i      (result_vec),
        .elem_idx_i (idx_q),
        .byte_idx_i (byte_q),
        .byte_o     (sel_byte)
    );

    assign tx_valid = (state_q == SEND);
    assign tx_data  = tx_valid ? sel_byte : 8'h00;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule
